// File: rtl/cabac_pkg.sv
// Shared types and constants for the CABAC bitstream byte feeder.
package cabac_pkg;

   localparam int BYTE_W     = 8;
   localparam int INIT_BYTES = 3;
   localparam int VALUE_W    = 24;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_INIT = 2'd1,
      ST_RUN  = 2'd2
   } state_e;

   // Byte slot 0 is the most significant byte of the initial m_value.
   function automatic logic [VALUE_W-1:0] place_init_byte(
      input logic [VALUE_W-1:0] value,
      input logic [BYTE_W-1:0]  b,
      input logic [1:0]         slot
   );
      logic [VALUE_W-1:0] r;
      r = value;
      case (slot)
         2'd0:    r[23:16] = b;
         2'd1:    r[15:8]  = b;
         2'd2:    r[7:0]   = b;
         default: r = value;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/cabac_byte_fifo.sv
// Show-ahead synchronous byte FIFO with flush and fill level.
module cabac_byte_fifo
   import cabac_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int LVL_W = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              push,
   input  logic              pop,
   input  logic [BYTE_W-1:0] din,
   output logic [BYTE_W-1:0] dout,
   output logic              full,
   output logic [LVL_W-1:0]  level
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [DEPTH-1:0][BYTE_W-1:0] mem_q, mem_d;
   logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]             rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]             level_q, level_d;
   logic                         push_ok_s, pop_ok_s;

   assign full  = (level_q == LVL_W'(DEPTH));
   assign level = level_q;
   assign dout  = mem_q[rd_ptr_q];

   // Next-state for storage, pointers and occupancy; flush drops any same-cycle push.
   always_comb begin
      mem_d     = mem_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      level_d   = level_q;
      push_ok_s = push & ~full;
      pop_ok_s  = pop & (level_q != LVL_W'(0));
      if (flush) begin
         wr_ptr_d = PTR_W'(0);
         rd_ptr_d = PTR_W'(0);
         level_d  = LVL_W'(0);
      end else begin
         if (push_ok_s) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
         endcase
      end
   end

   // State registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q    <= '0;
         wr_ptr_q <= PTR_W'(0);
         rd_ptr_q <= PTR_W'(0);
         level_q  <= LVL_W'(0);
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

endmodule

// File: rtl/cabac_byte_feeder.sv
// Byte supplier for the arithmetic decoder: slice-start m_value assembly, then per-request bytes.
module cabac_byte_feeder
   import cabac_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int LVL_W = $clog2(DEPTH) + 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               flush,
   input  logic [BYTE_W-1:0]  s_data,
   input  logic               s_valid,
   output logic               s_ready,
   input  logic               request_byte,
   output logic [BYTE_W-1:0]  byte_out,
   output logic               byte_valid,
   output logic               stall,
   output logic [VALUE_W-1:0] init_value,
   output logic               init_valid,
   output logic               running,
   output logic [LVL_W-1:0]   level
);

   state_e              state_q, state_d;
   logic [1:0]          cnt_q, cnt_d;
   logic [VALUE_W-1:0]  init_value_q, init_value_d;
   logic                running_q;
   logic                pop_s, full_s, have_byte_s;
   logic [BYTE_W-1:0]   head_s;

   cabac_byte_fifo #(.DEPTH(DEPTH), .LVL_W(LVL_W)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .push  (s_valid),
      .pop   (pop_s),
      .din   (s_data),
      .dout  (head_s),
      .full  (full_s),
      .level (level)
   );

   assign s_ready     = ~full_s;
   assign have_byte_s = (level != LVL_W'(0));
   assign byte_out    = head_s;
   assign init_value  = init_value_q;
   assign running     = running_q;

   // Sequencing: flush beats start, start beats normal INIT/RUN work.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      init_value_d = init_value_q;
      pop_s        = 1'b0;
      init_valid   = 1'b0;
      byte_valid   = 1'b0;
      stall        = 1'b0;
      if (flush) begin
         state_d = ST_IDLE;
         cnt_d   = 2'd0;
      end else if (start) begin
         state_d = ST_INIT;
         cnt_d   = 2'd0;
      end else begin
         case (state_q)
            ST_IDLE: state_d = ST_IDLE;
            ST_INIT: begin
               if (have_byte_s) begin
                  pop_s        = 1'b1;
                  init_value_d = place_init_byte(init_value_q, head_s, cnt_q);
                  if (cnt_q == 2'(INIT_BYTES - 1)) begin
                     init_valid = 1'b1;
                     cnt_d      = 2'd0;
                     state_d    = ST_RUN;
                  end else begin
                     cnt_d = cnt_q + 2'd1;
                  end
               end else begin
                  cnt_d = cnt_q;
               end
            end
            ST_RUN: begin
               if (request_byte) begin
                  if (have_byte_s) begin
                     pop_s      = 1'b1;
                     byte_valid = 1'b1;
                  end else begin
                     stall = 1'b1;
                  end
               end else begin
                  pop_s = 1'b0;
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = 2'd0;
            end
         endcase
      end
   end

   // FSM and registered status.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= 2'd0;
         init_value_q <= '0;
         running_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         init_value_q <= init_value_d;
         running_q    <= (state_d == ST_RUN);
      end
   end

endmodule

// File: doc/cabac_byte_feeder.md
Name: cabac_byte_feeder

Overview:
- Bitstream byte supplier directly downstream of the bitsNeeded stage of the VVC arithmetic decoder.
- Buffers slice-data bytes from the stream interface in a small FIFO.
- At slice start, assembles the 24-bit initial m_value from the first three bytes.
- During decoding, serves one byte per request_byte pulse, or asserts stall when starved.

Parameters:
- DEPTH, 4, FIFO depth in bytes; power of two, at least 4.
- LVL_W, $clog2(DEPTH)+1, width of the fill-level counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse: begin slice initialisation.
- flush  input  1  one-cycle pulse: empty the FIFO and return to IDLE.
- s_data  input  8  incoming bitstream byte.
- s_valid  input  1  s_data valid.
- s_ready  output  1  FIFO can accept a byte.
- request_byte  input  1  from the bitsNeeded stage; a byte is needed this cycle.
- byte_out  output  8  byte delivered to the m_value update.
- byte_valid  output  1  byte_out is consumed this cycle.
- stall  output  1  request pending but no byte available; decoder must hold.
- init_value  output  24  {b0,b1,b2} initial m_value.
- init_valid  output  1  one-cycle pulse: init_value is final.
- running  output  1  FSM is in RUN.
- level  output  LVL_W  current FIFO occupancy.

Behaviour:
- Reset (async, rst=1):
  - FIFO empty, level=0, FSM=IDLE, init_value=0.
  - init_valid=0, running=0, stall=0, byte_valid=0, byte_out=0.
  - s_ready=1 after reset is released.
- FIFO:
  - Show-ahead; head byte is visible combinationally.
  - push = s_valid & s_ready, with s_ready = (level != DEPTH). Not dependent on a same-cycle pop.
  - Pointers wrap modulo DEPTH. level increments on push-only, decrements on pop-only, and is unchanged on push+pop.
  - A pushed byte is poppable from the next cycle only; there is no empty-FIFO bypass.
- FSM states: IDLE, INIT, RUN.
  - IDLE: request_byte ignored; byte_valid=0, stall=0. start -> INIT and clears the 2-bit byte counter cnt.
  - INIT: each cycle with level>0 pops one byte into init_value[23-8*cnt -: 8] and increments cnt.
    - On the pop with cnt==2: init_valid=1 that cycle (combinational from the pop), init_value is registered at the edge, next state RUN.
    - init_value is stable from the cycle after init_valid until the next start.
    - request_byte is ignored; stall=0.
  - RUN: running=1.
    - request_byte & level>0: byte_out=head, byte_valid=1, pop at the edge.
    - request_byte & level==0: stall=1, byte_valid=0, no pop. The upstream stage holds request_byte until stall falls.
    - No request: byte_valid=0, stall=0. byte_out holds the head value (don't-care for consumers).
- start in INIT or RUN: restarts INIT with cnt=0; the FIFO is kept (bytes already belong to the new slice).
- flush in any state: FIFO emptied, FSM to IDLE, cnt=0. A push in the same cycle is dropped. Flush has priority over start.
- Simultaneous push and pop on a full FIFO: s_ready=0, so pop only and level decrements.
- Simultaneous push and pop on an empty FIFO: pop is impossible (stall or INIT wait), push only.
- stall and byte_valid are mutually exclusive and both are 0 outside RUN.

Decomposition:
- Shared package cabac_pkg: FSM state enum (IDLE, INIT, RUN), BYTE_W=8, INIT_BYTES=3, VALUE_W=24.
- One natural sub-module: cabac_byte_fifo (parameterised show-ahead sync FIFO with push/pop/flush/level). The FSM and init assembly live in the top.

Test Plan:
- Reset mid-INIT after 1 byte popped -> all outputs 0 immediately, level=0. After release, start plus bytes 0x12,0x34,0x56 -> init_value=0x123456 with a one-cycle init_valid, running=1 the next cycle.
- RUN with FIFO holding 0xA1,0xB2 and request_byte high for 3 cycles -> byte_out 0xA1 then 0xB2 with byte_valid, third cycle stall=1, level=0. Push 0xC3 -> next cycle byte_out=0xC3, stall=0.
- Fill 4 bytes with no requests -> s_ready=0 at level=4. Request plus s_valid same cycle -> pop only, level=3, s_ready=1 the next cycle.
- Steady push+pop every cycle at level=2 over 8 cycles (pointer wrap) -> bytes delivered in order, level constant at 2.
- Flush asserted together with start and s_valid at level=3 -> FSM=IDLE, level=0, pushed byte dropped, init_valid never pulses.
- INIT with a starved stream (bytes arriving every 3rd cycle) -> stall stays 0, init_valid pulses only on the third pop, and request_byte during INIT produces no pop.
